// File: rtl/arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, requester side,
// and the request record captured by each holding slot.
package arb_pkg;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int TRD_W   = 3;
   localparam int NUM_TRD = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   typedef enum logic {
      SIDE_I = 1'b0,
      SIDE_D = 1'b1
   } side_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [TRD_W-1:0]  trd;
      logic              wr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   function automatic logic addr_bad(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] limit);
      return (addr >= limit) || (addr[1:0] != 2'b00);
   endfunction

   function automatic logic [NUM_TRD-1:0] trd_onehot(input logic [TRD_W-1:0] trd);
      logic [NUM_TRD-1:0] v;
      v      = '0;
      v[trd] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/req_slot.sv
// One-entry request holding register with a valid/ready handshake.
// The slot stays full from acceptance until the arbiter clears it.
module req_slot
   import arb_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic req_valid,
   output logic req_ready,
   input  req_t req_in,
   input  logic clear,
   output logic accept,
   output logic full,
   output req_t slot
);

   logic full_q, full_d;
   req_t slot_q, slot_d;

   assign req_ready = rst_n & ~full_q;
   assign full      = full_q;
   assign slot      = slot_q;

   always_comb begin
      accept = req_valid & req_ready;
      full_d = full_q;
      slot_d = slot_q;
      if (clear) begin
         full_d = 1'b0;
      end
      if (accept) begin
         full_d = 1'b1;
         slot_d = req_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         slot_q <= '0;
      end else begin
         full_q <= full_d;
         slot_q <= slot_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the instruction and
// data refill paths, with per-thread miss tracking and local segfault checks.
module mem_port_arbiter
   import arb_pkg::*;
#(
   parameter logic [31:0] MEM_BYTES = 32'h0001_0000,
   parameter int unsigned TIMEOUT   = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ireq_valid,
   output logic        ireq_ready,
   input  logic [31:0] ireq_addr,
   input  logic [2:0]  ireq_trd,
   input  logic        dreq_valid,
   output logic        dreq_ready,
   input  logic [31:0] dreq_addr,
   input  logic        dreq_wr,
   input  logic [31:0] dreq_wdata,
   input  logic [2:0]  dreq_trd,
   output logic        iresp_valid,
   output logic [31:0] iresp_data,
   output logic [2:0]  iresp_trd,
   output logic        iresp_segfault,
   output logic        dresp_valid,
   output logic [31:0] dresp_data,
   output logic [2:0]  dresp_trd,
   output logic        dresp_segfault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic [7:0]  miss_trd,
   output logic        mem_timeout
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   req_t i_req_in, d_req_in, i_slot, d_slot, sel_slot, pick_slot;
   logic i_full, d_full, i_accept, d_accept, i_clear, d_clear;

   state_e state_q, state_d;
   side_e  sel_q, sel_d, last_gnt_q, last_gnt_d, pick;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

   logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
   logic        timeout_q, timeout_d;
   logic [7:0]  miss_q, miss_d, miss_set, miss_clr;

   logic        rsp_go, rsp_seg;
   side_e       rsp_side;
   logic [2:0]  rsp_trd;
   logic [31:0] rsp_data;

   logic        ivalid_q, ivalid_d, iseg_q, iseg_d;
   logic [31:0] idata_q, idata_d;
   logic [2:0]  itrd_q, itrd_d;
   logic        dvalid_q, dvalid_d, dseg_q, dseg_d;
   logic [31:0] ddata_q, ddata_d;
   logic [2:0]  dtrd_q, dtrd_d;

   assign i_req_in = '{addr: ireq_addr, trd: ireq_trd, wr: 1'b0, wdata: 32'h0};
   assign d_req_in = '{addr: dreq_addr, trd: dreq_trd, wr: dreq_wr, wdata: dreq_wdata};

   req_slot u_islot (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (ireq_valid),
      .req_ready (ireq_ready),
      .req_in    (i_req_in),
      .clear     (i_clear),
      .accept    (i_accept),
      .full      (i_full),
      .slot      (i_slot)
   );

   req_slot u_dslot (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (dreq_valid),
      .req_ready (dreq_ready),
      .req_in    (d_req_in),
      .clear     (d_clear),
      .accept    (d_accept),
      .full      (d_full),
      .slot      (d_slot)
   );

   assign sel_slot = (sel_q == SIDE_I) ? i_slot : d_slot;
   assign i_clear  = (state_q == RESP) && (sel_q == SIDE_I);
   assign d_clear  = (state_q == RESP) && (sel_q == SIDE_D);

   // On a tie the side that did not win last time gets the port.
   always_comb begin
      if (i_full && d_full) begin
         pick = (last_gnt_q == SIDE_I) ? SIDE_D : SIDE_I;
      end else if (i_full) begin
         pick = SIDE_I;
      end else begin
         pick = SIDE_D;
      end
      pick_slot = (pick == SIDE_I) ? i_slot : d_slot;
   end

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      last_gnt_d  = last_gnt_q;
      cnt_d       = cnt_q;
      cnt_inc     = cnt_q + CNT_W'(1);
      mem_req_d   = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = 32'h0;
      mem_wdata_d = 32'h0;
      timeout_d   = timeout_q;
      rsp_go      = 1'b0;
      rsp_seg     = 1'b0;
      rsp_side    = sel_q;
      rsp_trd     = sel_slot.trd;
      rsp_data    = 32'h0;

      case (state_q)
         IDLE: begin
            if (i_full || d_full) begin
               sel_d = pick;
               if (addr_bad(pick_slot.addr, MEM_BYTES)) begin
                  state_d  = RESP;
                  rsp_go   = 1'b1;
                  rsp_seg  = 1'b1;
                  rsp_side = pick;
                  rsp_trd  = pick_slot.trd;
               end else begin
                  state_d     = ISSUE;
                  mem_req_d   = 1'b1;
                  mem_we_d    = pick_slot.wr;
                  mem_addr_d  = pick_slot.addr;
                  mem_wdata_d = pick_slot.wdata;
               end
            end
         end
         ISSUE: begin
            if (mem_gnt) begin
               state_d = WAIT;
               cnt_d   = '0;
            end else begin
               mem_req_d   = 1'b1;
               mem_we_d    = sel_slot.wr;
               mem_addr_d  = sel_slot.addr;
               mem_wdata_d = sel_slot.wdata;
            end
         end
         WAIT: begin
            cnt_d = cnt_inc;
            if (mem_rvalid) begin
               state_d  = RESP;
               rsp_go   = 1'b1;
               rsp_data = sel_slot.wr ? 32'h0 : mem_rdata;
            end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
               state_d   = RESP;
               rsp_go    = 1'b1;
               rsp_seg   = 1'b1;
               timeout_d = 1'b1;
            end
         end
         RESP: begin
            last_gnt_d = sel_q;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Response registers pulse for exactly the one cycle spent in RESP.
   always_comb begin
      ivalid_d = 1'b0;
      idata_d  = 32'h0;
      itrd_d   = 3'h0;
      iseg_d   = 1'b0;
      dvalid_d = 1'b0;
      ddata_d  = 32'h0;
      dtrd_d   = 3'h0;
      dseg_d   = 1'b0;
      if (rsp_go) begin
         if (rsp_side == SIDE_I) begin
            ivalid_d = 1'b1;
            idata_d  = rsp_data;
            itrd_d   = rsp_trd;
            iseg_d   = rsp_seg;
         end else begin
            dvalid_d = 1'b1;
            ddata_d  = rsp_data;
            dtrd_d   = rsp_trd;
            dseg_d   = rsp_seg;
         end
      end

      miss_set = '0;
      if (i_accept) begin
         miss_set = miss_set | trd_onehot(ireq_trd);
      end
      if (d_accept) begin
         miss_set = miss_set | trd_onehot(dreq_trd);
      end
      miss_clr = (state_q == RESP) ? trd_onehot(sel_slot.trd) : 8'h00;
      miss_d   = (miss_q & ~miss_clr) | miss_set;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sel_q       <= SIDE_I;
         last_gnt_q  <= SIDE_D;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         timeout_q   <= 1'b0;
         miss_q      <= 8'h00;
         ivalid_q    <= 1'b0;
         idata_q     <= 32'h0;
         itrd_q      <= 3'h0;
         iseg_q      <= 1'b0;
         dvalid_q    <= 1'b0;
         ddata_q     <= 32'h0;
         dtrd_q      <= 3'h0;
         dseg_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         last_gnt_q  <= last_gnt_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         timeout_q   <= timeout_d;
         miss_q      <= miss_d;
         ivalid_q    <= ivalid_d;
         idata_q     <= idata_d;
         itrd_q      <= itrd_d;
         iseg_q      <= iseg_d;
         dvalid_q    <= dvalid_d;
         ddata_q     <= ddata_d;
         dtrd_q      <= dtrd_d;
         dseg_q      <= dseg_d;
      end
   end

   assign mem_req        = mem_req_q;
   assign mem_we         = mem_we_q;
   assign mem_addr       = mem_addr_q;
   assign mem_wdata      = mem_wdata_q;
   assign mem_timeout    = timeout_q;
   assign miss_trd       = miss_q;
   assign iresp_valid    = ivalid_q;
   assign iresp_data     = idata_q;
   assign iresp_trd      = itrd_q;
   assign iresp_segfault = iseg_q;
   assign dresp_valid    = dvalid_q;
   assign dresp_data     = ddata_q;
   assign dresp_trd      = dtrd_q;
   assign dresp_segfault = dseg_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: a vector table of single
// transactions plus hand-written arbitration, timeout and reset sequences.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ireq_valid, ireq_ready;
   logic [31:0] ireq_addr;
   logic [2:0]  ireq_trd;
   logic        dreq_valid, dreq_ready;
   logic [31:0] dreq_addr;
   logic        dreq_wr;
   logic [31:0] dreq_wdata;
   logic [2:0]  dreq_trd;
   logic        iresp_valid, iresp_segfault;
   logic [31:0] iresp_data;
   logic [2:0]  iresp_trd;
   logic        dresp_valid, dresp_segfault;
   logic [31:0] dresp_data;
   logic [2:0]  dresp_trd;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;
   logic [7:0]  miss_trd;
   logic        mem_timeout;

   int checks = 0;
   int passed = 0;

   // Memory responder mode: 0 normal, 1 grant without rvalid, 2 rvalid every cycle.
   int mem_mode = 0;
   logic [31:0] gnt_log[$];

   typedef struct {
      bit          is_d;
      logic [31:0] addr;
      bit          wr;
      logic [31:0] wdata;
      logic [2:0]  trd;
      logic [31:0] exp_data;
      bit          exp_seg;
      bit          exp_mem;
      int          exp_lat;
      string       name;
   } vec_t;

   vec_t vecs[8];
   vec_t tmo_vec;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ireq_valid     (ireq_valid),
      .ireq_ready     (ireq_ready),
      .ireq_addr      (ireq_addr),
      .ireq_trd       (ireq_trd),
      .dreq_valid     (dreq_valid),
      .dreq_ready     (dreq_ready),
      .dreq_addr      (dreq_addr),
      .dreq_wr        (dreq_wr),
      .dreq_wdata     (dreq_wdata),
      .dreq_trd       (dreq_trd),
      .iresp_valid    (iresp_valid),
      .iresp_data     (iresp_data),
      .iresp_trd      (iresp_trd),
      .iresp_segfault (iresp_segfault),
      .dresp_valid    (dresp_valid),
      .dresp_data     (dresp_data),
      .dresp_trd      (dresp_trd),
      .dresp_segfault (dresp_segfault),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_gnt        (mem_gnt),
      .mem_rvalid     (mem_rvalid),
      .mem_rdata      (mem_rdata),
      .miss_trd       (miss_trd),
      .mem_timeout    (mem_timeout)
   );

   // Backing memory contents as seen by reads.
   function automatic logic [31:0] memData(input logic [31:0] addr);
      if (addr == 32'h0000_0100) begin
         return 32'hDEAD_BEEF;
      end
      return {addr[15:0], ~addr[15:0]};
   endfunction

   // Memory model: grants immediately, answers one cycle after the grant.
   initial begin
      logic        pending;
      logic [31:0] pend_addr;
      pending    = 1'b0;
      pend_addr  = 32'h0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      forever begin
         @(posedge clk);
         #2;
         if (pending && mem_mode == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = memData(pend_addr);
         end else if (mem_mode == 2) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h5555_AAAA;
         end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
         end
         pending = 1'b0;
         if (mem_req) begin
            mem_gnt   = 1'b1;
            pend_addr = mem_addr;
            pending   = 1'b1;
            gnt_log.push_back(mem_addr);
         end else begin
            mem_gnt = 1'b0;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Runs one transaction to completion and checks its timing and response.
   task automatic applyStimulus(input vec_t v);
      int         lat;
      bit         seen;
      bit         saw_req;
      logic [7:0] exp_miss;
      exp_miss = 8'h01 << v.trd;
      checkOutput({v.name, " ready"}, 32'(v.is_d ? dreq_ready : ireq_ready), 32'd1);
      if (v.is_d) begin
         dreq_valid = 1'b1;
         dreq_addr  = v.addr;
         dreq_wr    = v.wr;
         dreq_wdata = v.wdata;
         dreq_trd   = v.trd;
      end else begin
         ireq_valid = 1'b1;
         ireq_addr  = v.addr;
         ireq_trd   = v.trd;
      end
      nextCycle();
      ireq_valid = 1'b0;
      dreq_valid = 1'b0;
      checkOutput({v.name, " miss_trd"}, 32'(miss_trd), 32'(exp_miss));
      seen    = 1'b0;
      saw_req = 1'b0;
      lat     = 0;
      for (int c = 1; c <= 100 && !seen; c++) begin
         if (c > 1) begin
            nextCycle();
         end
         if (mem_req) begin
            saw_req = 1'b1;
         end
         if (c == 2 && v.exp_mem) begin
            checkOutput({v.name, " mem_req"}, 32'(mem_req), 32'd1);
            checkOutput({v.name, " mem_we"}, 32'(mem_we), 32'(v.wr));
            checkOutput({v.name, " mem_addr"}, mem_addr, v.addr);
            if (v.wr) begin
               checkOutput({v.name, " mem_wdata"}, mem_wdata, v.wdata);
            end
         end
         if (iresp_valid || dresp_valid) begin
            seen = 1'b1;
            lat  = c;
            checkOutput({v.name, " resp side"}, 32'(dresp_valid), 32'(v.is_d));
            checkOutput({v.name, " resp data"}, v.is_d ? dresp_data : iresp_data, v.exp_data);
            checkOutput({v.name, " resp trd"}, 32'(v.is_d ? dresp_trd : iresp_trd), 32'(v.trd));
            checkOutput({v.name, " resp segfault"},
                        32'(v.is_d ? dresp_segfault : iresp_segfault), 32'(v.exp_seg));
         end
      end
      checkOutput({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
      if (!v.exp_mem) begin
         checkOutput({v.name, " no mem_req"}, 32'(saw_req), 32'd0);
      end
      nextCycle();
      checkOutput({v.name, " ready after"}, 32'(v.is_d ? dreq_ready : ireq_ready), 32'd1);
      checkOutput({v.name, " miss cleared"}, 32'(miss_trd), 32'd0);
      checkOutput({v.name, " resp pulse"}, 32'(iresp_valid | dresp_valid), 32'd0);
   endtask

   // Both sides request together; I must be served before D.
   task automatic dualRound(input int r);
      logic [31:0] iaddr, daddr;
      logic [7:0]  exp_miss;
      int          base, nresp;
      string       tag;
      tag      = $sformatf("round%0d", r);
      iaddr    = 32'h1000 + 32'(r * 16);
      daddr    = 32'h2000 + 32'(r * 16);
      exp_miss = (8'h01 << r) | (8'h01 << (r + 4));
      checkOutput({tag, " both ready"}, 32'(ireq_ready & dreq_ready), 32'd1);
      ireq_valid = 1'b1;
      ireq_addr  = iaddr;
      ireq_trd   = 3'(r);
      dreq_valid = 1'b1;
      dreq_addr  = daddr;
      dreq_wr    = 1'b0;
      dreq_wdata = 32'h0;
      dreq_trd   = 3'(r + 4);
      base       = gnt_log.size();
      nextCycle();
      ireq_valid = 1'b0;
      dreq_valid = 1'b0;
      checkOutput({tag, " miss_trd"}, 32'(miss_trd), 32'(exp_miss));
      nresp = 0;
      for (int c = 1; c <= 30 && nresp < 2; c++) begin
         if (iresp_valid || dresp_valid) begin
            if (nresp == 0) begin
               checkOutput({tag, " first is I"}, 32'(iresp_valid & ~dresp_valid), 32'd1);
               checkOutput({tag, " I data"}, iresp_data, memData(iaddr));
            end else begin
               checkOutput({tag, " second is D"}, 32'(dresp_valid & ~iresp_valid), 32'd1);
               checkOutput({tag, " D data"}, dresp_data, memData(daddr));
            end
            nresp++;
         end
         nextCycle();
      end
      checkOutput({tag, " response count"}, 32'(nresp), 32'd2);
      checkOutput({tag, " grant count"}, 32'(gnt_log.size() - base), 32'd2);
      if (gnt_log.size() - base == 2) begin
         checkOutput({tag, " grant0 addr"}, gnt_log[base], iaddr);
         checkOutput({tag, " grant1 addr"}, gnt_log[base + 1], daddr);
      end
   endtask

   initial begin
      int nresp;
      vecs[0] = '{is_d: 0, addr: 32'h0000_0100, wr: 0, wdata: 32'h0, trd: 3'd2,
                  exp_data: 32'hDEAD_BEEF, exp_seg: 0, exp_mem: 1, exp_lat: 4, name: "i_rd_100"};
      vecs[1] = '{is_d: 1, addr: 32'h0000_0200, wr: 1, wdata: 32'h1234_5678, trd: 3'd5,
                  exp_data: 32'h0, exp_seg: 0, exp_mem: 1, exp_lat: 4, name: "d_wr_200"};
      vecs[2] = '{is_d: 1, addr: 32'h0001_0000, wr: 0, wdata: 32'h0, trd: 3'd1,
                  exp_data: 32'h0, exp_seg: 1, exp_mem: 0, exp_lat: 2, name: "d_rd_range"};
      vecs[3] = '{is_d: 1, addr: 32'h0000_0102, wr: 0, wdata: 32'h0, trd: 3'd3,
                  exp_data: 32'h0, exp_seg: 1, exp_mem: 0, exp_lat: 2, name: "d_rd_misalign"};
      vecs[4] = '{is_d: 0, addr: 32'h0000_0204, wr: 0, wdata: 32'h0, trd: 3'd7,
                  exp_data: 32'h0204_FDFB, exp_seg: 0, exp_mem: 1, exp_lat: 4, name: "i_rd_204"};
      vecs[5] = '{is_d: 0, addr: 32'h0000_FFFC, wr: 0, wdata: 32'h0, trd: 3'd0,
                  exp_data: 32'hFFFC_0003, exp_seg: 0, exp_mem: 1, exp_lat: 4, name: "i_rd_top"};
      vecs[6] = '{is_d: 0, addr: 32'h8000_0000, wr: 0, wdata: 32'h0, trd: 3'd4,
                  exp_data: 32'h0, exp_seg: 1, exp_mem: 0, exp_lat: 2, name: "i_rd_high"};
      vecs[7] = '{is_d: 1, addr: 32'h0000_03FC, wr: 0, wdata: 32'h0, trd: 3'd6,
                  exp_data: 32'h03FC_FC03, exp_seg: 0, exp_mem: 1, exp_lat: 4, name: "d_rd_3fc"};
      tmo_vec = '{is_d: 1, addr: 32'h0000_0040, wr: 0, wdata: 32'h0, trd: 3'd3,
                  exp_data: 32'h0, exp_seg: 1, exp_mem: 1, exp_lat: 67, name: "d_timeout"};

      rst_n      = 1'b0;
      ireq_valid = 1'b0;
      ireq_addr  = 32'h0;
      ireq_trd   = 3'h0;
      dreq_valid = 1'b0;
      dreq_addr  = 32'h0;
      dreq_wr    = 1'b0;
      dreq_wdata = 32'h0;
      dreq_trd   = 3'h0;
      repeat (3) nextCycle();
      checkOutput("reset ireq_ready", 32'(ireq_ready), 32'd0);
      checkOutput("reset dreq_ready", 32'(dreq_ready), 32'd0);
      checkOutput("reset mem_req", 32'(mem_req), 32'd0);
      checkOutput("reset miss_trd", 32'(miss_trd), 32'd0);
      checkOutput("reset mem_timeout", 32'(mem_timeout), 32'd0);
      checkOutput("reset resp_valid", 32'(iresp_valid | dresp_valid), 32'd0);
      rst_n = 1'b1;
      nextCycle();

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i]);
      end

      for (int r = 0; r < 4; r++) begin
         dualRound(r);
      end

      // Grant without data: the wait counter must expire and report.
      checkOutput("pre-timeout flag", 32'(mem_timeout), 32'd0);
      mem_mode = 1;
      applyStimulus(tmo_vec);
      checkOutput("mem_timeout set", 32'(mem_timeout), 32'd1);
      mem_mode = 2;
      nresp    = 0;
      for (int c = 0; c < 4; c++) begin
         nextCycle();
         if (iresp_valid || dresp_valid) begin
            nresp++;
         end
      end
      mem_mode = 0;
      checkOutput("late rvalid dropped", 32'(nresp), 32'd0);
      checkOutput("mem_timeout sticky", 32'(mem_timeout), 32'd1);
      nextCycle();

      // Reset while waiting on memory.
      mem_mode   = 1;
      ireq_valid = 1'b1;
      ireq_addr  = 32'h0000_0300;
      ireq_trd   = 3'd6;
      nextCycle();
      ireq_valid = 1'b0;
      nextCycle();
      nextCycle();
      checkOutput("mid-wait miss_trd", 32'(miss_trd), 32'h40);
      rst_n = 1'b0;
      nextCycle();
      checkOutput("rst mem_req", 32'(mem_req), 32'd0);
      checkOutput("rst miss_trd", 32'(miss_trd), 32'd0);
      checkOutput("rst mem_timeout", 32'(mem_timeout), 32'd0);
      checkOutput("rst readies", 32'(ireq_ready | dreq_ready), 32'd0);
      checkOutput("rst resp_valid", 32'(iresp_valid | dresp_valid), 32'd0);
      rst_n    = 1'b1;
      mem_mode = 0;
      nresp    = 0;
      for (int c = 0; c < 5; c++) begin
         nextCycle();
         if (iresp_valid || dresp_valid || mem_req) begin
            nresp++;
         end
      end
      checkOutput("post-reset quiet", 32'(nresp), 32'd0);
      applyStimulus(vecs[0]);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
